uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
//  Bus-mapped 8N1 UART transmitter; the send-side partner of the UART receiver on the same bus.
//  CPU writes a byte, the block serialises it LSB first on tx at BAUDRATE.
//  Status register exposes holding-empty/busy/overrun; o_int pulses at end of each frame.
// PARAMETERS
//  SYS_CLK     50_000_000  system clock frequency, Hz
//  BAUDRATE    115200      line rate, bit/s; TICK = SYS_CLK/BAUDRATE clocks per bit (434 default)
//  FIFO_DEPTH  4           entries in TX FIFO (power of 2, >=2); used only with UART_TX_FIFO_EN
// PORTS
//  i_clk    in   1  system clock, all logic on posedge
//  i_reset  in   1  asynchronous, active-high reset
//  i_dat    in   8  write data (byte to send)
//  o_dat    out  8  read data: i_addr=1 -> {5'd0, OV, BUSY, TXE}; i_addr=0 -> 8'd0
//  i_addr   in   1  register select: 0 = TX data, 1 = status
//  i_we     in   1  write enable
//  i_cyc    in   1  bus cycle valid
//  tx       out  1  serial line out, idle high
//  o_int    out  1  one-cycle pulse when a frame's stop bit completes
// BEHAVIOUR
//  Reset (async, any time incl. mid-frame): tx=1, o_int=0, state IDLE, holding/FIFO empty,
//   status TXE=1 BUSY=0 OV=0, baud counter 0. Frame in progress is abandoned.
//  Write: i_cyc&i_we&i_addr==0 in cycle N. Accepted if slot free (TXE=1) or the shifter
//   takes the held byte in the same cycle; else byte dropped and OV<=1.
//  Status read: i_cyc&~i_we&i_addr==1 clears OV at that edge (read returns pre-clear value).
//   Concurrent drop + status read: OV ends 1 (set wins).
//  o_dat combinational from i_addr; TXE = slot free, BUSY = FSM not IDLE.
//  Baud counter: width $clog2(TICK+1); cleared on frame start; bit_end when count==TICK-1,
//   then wraps to 0. Every bit on tx lasts exactly TICK clocks.
//  FSM states: IDLE, START, DATA (bit index 0..7), STOP.
//   IDLE : slot full -> load shifter, free slot, clear baud counter, -> START.
//   START: tx=0; bit_end -> DATA idx 0.
//   DATA : tx=shift[idx]; bit_end -> idx+1; after idx 7 -> STOP.
//   STOP : tx=1; bit_end -> o_int=1 for 1 clk; slot full -> START directly
//          (back-to-back, no idle gap), else -> IDLE.
//  Latency: write at edge N -> tx falls at edge N+2 when idle; frame length 10*TICK clocks.
//  tx is registered (no glitches); tx=1 in IDLE and STOP.
// CONFIGURATION
//  UART_TX_FIFO_EN defined: holding register replaced by FIFO_DEPTH-entry FIFO; TXE = not
//   full; drop/OV only when full; back-to-back frames until empty; status bit3 = EMPTY.
//  Undefined: single 8-bit holding register; TXE = holding empty; status bit3 = 0.
// STRUCTURE
//  Shared package uart_pkg: register addresses (UART_REG_DATA=0, UART_REG_STATUS=1),
//   status bit indices (TXE=0, BUSY=1, OV=2, EMPTY=3), FSM state encodings, TICK function.
//  Sub-module uart_tx_fifo (sync FIFO, push/pop/full/empty, wrap-around pointers with
//   extra MSB); instantiated only under UART_TX_FIFO_EN.
//  Baud counter and FSM/shifter inline in uart_tx.
// TESTING (SYS_CLK=50e6, BAUDRATE=115200, TICK=434)
//  Write 0x55 while idle -> tx low 2 clks later; bits 1,0,1,0,1,0,1,0 then stop, each 434 clks;
//   o_int single pulse at frame end; status reads 0x03 mid-frame, 0x01 after.
//  Write 0xA3 then 0x0F during first frame -> two frames back-to-back, no idle gap, 2 o_int.
//  Three writes mid-frame, no FIFO -> third dropped, status OV=1; status read -> OV cleared.
//  With UART_TX_FIFO_EN, 5 writes of 0x01..0x05 -> 4 queued + 1 in shifter sent in order,
//   6th write while full sets OV; EMPTY=1 after last frame.
//  Assert i_reset mid DATA bit 3 -> tx=1 immediately, status 0x01, no o_int; next write
//   transmits a clean full frame.
//  Write coincident with STOP bit_end while slot full -> accepted, no OV, frames in order.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART bus blocks: register map, status bit
// positions, transmitter FSM encoding and the bit-period helper.
package uart_pkg;

    // Register map (one address bit)
    localparam logic UART_REG_DATA   = 1'b0;
    localparam logic UART_REG_STATUS = 1'b1;

    // Status register bit positions
    localparam int STAT_TXE   = 0;
    localparam int STAT_BUSY  = 1;
    localparam int STAT_OV    = 2;
    localparam int STAT_EMPTY = 3;

    // Transmitter frame states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    // Clocks per serial bit
    function automatic int uart_tick(input int sys_clk, input int baudrate);
        return sys_clk / baudrate;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO for the transmitter. Pointers carry one extra MSB so
// full and empty are told apart without a separate counter. Read data is
// show-ahead: o_data always presents the oldest entry so the shifter can load
// it in the same cycle it pops. A push while full is legal only together with
// a pop (the slot being read is the one being overwritten).
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;

    assign o_empty = (wr_ptr_q == rd_ptr_q);
    assign o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign o_data  = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer update: wrap-around counters, advanced independently
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (i_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (i_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage write; contents need no reset since the pointers gate validity
    always_ff @(posedge i_clk) begin
        if (i_push) mem_q[wr_ptr_q[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/uart_tx.sv
// Bus-mapped 8N1 UART transmitter. The CPU writes a byte to the data register,
// the byte is serialised LSB first on tx. The status register reports
// {EMPTY, OV, BUSY, TXE}; o_int pulses for one clock as each stop bit ends.
// Build option UART_TX_FIFO_EN: replaces the single holding register with a
// FIFO_DEPTH-entry FIFO (status bit 3 then reports FIFO empty).
// tx is registered from the current state, so it trails the FSM by one clock:
// a write sampled at edge N is loaded at N+1 and tx falls at N+2.
module uart_tx
    import uart_pkg::*;
#(
    parameter int SYS_CLK    = 50_000_000,
    parameter int BAUDRATE   = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [7:0] i_dat,
    output logic [7:0] o_dat,
    input  logic       i_addr,
    input  logic       i_we,
    input  logic       i_cyc,
    output logic       tx,
    output logic       o_int
);

    localparam int             TICK      = uart_tick(SYS_CLK, BAUDRATE);
    localparam int             CW        = $clog2(TICK + 1);
    localparam logic [CW-1:0]  TICK_LAST = CW'(TICK - 1);

    tx_state_e     state_q;
    logic [2:0]    idx_q;
    logic [7:0]    shift_q;
    logic          tx_q;
    logic          int_q;
    logic [CW-1:0] baud_q;
    logic          ov_q;
    logic          ov_d;

    logic          wr_data;
    logic          rd_status;
    logic          bit_end;
    logic          slot_full;
    logic [7:0]    slot_data;
    logic          txe;
    logic          empty_flag;
    logic          take;
    logic          accept;
    logic          drop;

    assign wr_data   = i_cyc & i_we & (i_addr == UART_REG_DATA);
    assign rd_status = i_cyc & ~i_we & (i_addr == UART_REG_STATUS);
    assign bit_end   = (state_q != ST_IDLE) && (baud_q == TICK_LAST);

    // The shifter pulls the next byte when idle, or at the end of a stop bit
    // so consecutive frames run with no idle gap.
    assign take   = slot_full & ((state_q == ST_IDLE) | ((state_q == ST_STOP) & bit_end));
    // A write also fits when the slot is being vacated in this very cycle.
    assign accept = wr_data & (txe | take);
    assign drop   = wr_data & ~accept;

`ifdef UART_TX_FIFO_EN
    logic fifo_full;
    logic fifo_empty;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (accept),
        .i_data  (i_dat),
        .i_pop   (take),
        .o_data  (slot_data),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    assign slot_full  = ~fifo_empty;
    assign txe        = ~fifo_full;
    assign empty_flag = fifo_empty;
`else
    logic [7:0] hold_q;
    logic       hold_full_q;
    // FIFO_DEPTH only matters when the FIFO is built
    logic [7:0] unused_fifo_depth;

    assign unused_fifo_depth = 8'(FIFO_DEPTH);

    // Single holding register: filled by an accepted write, emptied on take
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            hold_q      <= 8'd0;
            hold_full_q <= 1'b0;
        end else if (accept) begin
            hold_q      <= i_dat;
            hold_full_q <= 1'b1;
        end else if (take) begin
            hold_full_q <= 1'b0;
        end
    end

    assign slot_full  = hold_full_q;
    assign slot_data  = hold_q;
    assign txe        = ~hold_full_q;
    assign empty_flag = 1'b0;
`endif

    // Overrun flag: a dropped write sets it, a status read clears it; set wins
    always_comb begin
        ov_d = ov_q;
        if (rd_status) ov_d = 1'b0;
        if (drop)      ov_d = 1'b1;
    end

    // Overrun register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) ov_q <= 1'b0;
        else         ov_q <= ov_d;
    end

    // Baud counter: held at zero while idle so every frame starts on a fresh bit
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)                            baud_q <= '0;
        else if (state_q == ST_IDLE || bit_end) baud_q <= '0;
        else                                    baud_q <= baud_q + CW'(1);
    end

    // Frame FSM with shifter, registered line output and end-of-frame pulse
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            idx_q   <= 3'd0;
            shift_q <= 8'd0;
            tx_q    <= 1'b1;
            int_q   <= 1'b0;
        end else begin
            int_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    tx_q <= 1'b1;
                    if (slot_full) begin
                        shift_q <= slot_data;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    tx_q <= 1'b0;
                    if (bit_end) begin
                        idx_q   <= 3'd0;
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    tx_q <= shift_q[idx_q];
                    if (bit_end) begin
                        if (idx_q == 3'd7) state_q <= ST_STOP;
                        else               idx_q   <= idx_q + 3'd1;
                    end
                end
                ST_STOP: begin
                    tx_q <= 1'b1;
                    if (bit_end) begin
                        int_q <= 1'b1;
                        if (slot_full) begin
                            shift_q <= slot_data;
                            state_q <= ST_START;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Register read mux
    always_comb begin
        o_dat = 8'd0;
        if (i_addr == UART_REG_STATUS) begin
            o_dat[STAT_TXE]   = txe;
            o_dat[STAT_BUSY]  = (state_q != ST_IDLE);
            o_dat[STAT_OV]    = ov_q;
            o_dat[STAT_EMPTY] = empty_flag;
        end
    end

    assign tx    = tx_q;
    assign o_int = int_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx (SYS_CLK=50 MHz, BAUDRATE=115200, TICK=434).
// A line monitor decodes frames from tx and flags any level change that does
// not fall on a bit boundary; tests compare decoded bytes, o_int counts and
// status values against expectations derived from the frame rules.
module tb_uart_tx;

    localparam int TICK = 50_000_000 / 115200;

`ifdef UART_TX_FIFO_EN
    localparam logic [7:0] ST_IDLE_EXP = 8'h09;
    localparam logic [7:0] ST_BUSY_EXP = 8'h0B;
    localparam logic [7:0] ST_COINC_EXP = 8'h03;
`else
    localparam logic [7:0] ST_IDLE_EXP = 8'h01;
    localparam logic [7:0] ST_BUSY_EXP = 8'h03;
    localparam logic [7:0] ST_COINC_EXP = 8'h02;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] dat_i = 8'd0;
    logic [7:0] dat_o;
    logic       addr = 1'b0;
    logic       we = 1'b0;
    logic       cyc = 1'b0;
    logic       tx;
    logic       intr;

    uart_tx #(
        .SYS_CLK    (50_000_000),
        .BAUDRATE   (115200),
        .FIFO_DEPTH (4)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .i_dat   (dat_i),
        .o_dat   (dat_o),
        .i_addr  (addr),
        .i_we    (we),
        .i_cyc   (cyc),
        .tx      (tx),
        .o_int   (intr)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    int          int_cnt = 0;
    int          mon_err = 0;
    longint      cyc_cnt = 0;
    logic [7:0]  rx_q[$];
    longint      start_q[$];
    bit          mbusy = 1'b0;
    int          mcnt = 0;
    logic [7:0]  mbyte = 8'd0;
    logic        mprev = 1'b1;

    always @(posedge clk) cyc_cnt++;

    // Line monitor: counts o_int pulses and decodes 8N1 frames at mid-bit
    always @(negedge clk) begin
        if (intr === 1'b1) int_cnt++;
        if (rst) begin
            mbusy = 1'b0;
        end else if (!mbusy) begin
            if (tx === 1'b0) begin
                mbusy = 1'b1;
                mcnt  = 0;
                mbyte = 8'd0;
                start_q.push_back(cyc_cnt);
            end
        end else begin
            mcnt++;
            if (tx !== mprev && (mcnt % TICK) != 0) mon_err++;
            if (mcnt == TICK / 2 && tx !== 1'b0) mon_err++;
            for (int b = 0; b < 8; b++)
                if (mcnt == (b + 1) * TICK + TICK / 2) mbyte[b] = tx;
            if (mcnt == 9 * TICK + TICK / 2) begin
                if (tx !== 1'b1) mon_err++;
                rx_q.push_back(mbyte);
                $display("rx frame 0x%02h at cycle %0d", mbyte, cyc_cnt);
                mbusy = 1'b0;
            end
        end
        mprev = tx;
    end

    task automatic do_write(input logic [7:0] b);
        dat_i = b; cyc = 1'b1; we = 1'b1; addr = 1'b0;
        @(posedge clk); #1;
        cyc = 1'b0; we = 1'b0;
    endtask

    task automatic read_status(output logic [7:0] v);
        cyc = 1'b1; we = 1'b0; addr = 1'b1;
        @(negedge clk);
        v = dat_o;
        @(posedge clk); #1;
        cyc = 1'b0; addr = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int budget, output bit ok);
        int k;
        k = 0;
        while (rx_q.size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        ok = (rx_q.size() >= n);
        repeat (TICK) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx); end
        n_checks++;
        if (intr !== 1'b0) begin n_fail++; $display("FAIL reset_int: got %b want 0", intr); end
        addr = 1'b1; #1;
        n_checks++;
        if (dat_o !== ST_IDLE_EXP) begin n_fail++; $display("FAIL reset_status: got %02h want %02h", dat_o, ST_IDLE_EXP); end
        addr = 1'b0; #1;
        n_checks++;
        if (dat_o !== 8'h00) begin n_fail++; $display("FAIL reset_data_reg: got %02h want 00", dat_o); end
        rst = 1'b0;
        @(posedge clk); #1;
        $display("test_reset done");
    endtask

    task automatic test_basic();
        logic [7:0] bytes [2];
        logic [7:0] b, st, mid;
        logic       exp_bit;
        int         bad [10];
        int         i0, e0;
        bytes[0] = 8'h55;
        bytes[1] = 8'($urandom_range(0, 255));
        for (int t = 0; t < 2; t++) begin
            b = bytes[t];
            rx_q.delete();
            i0 = int_cnt; e0 = mon_err;
            for (int i = 0; i < 10; i++) bad[i] = 0;
            mid = 8'h00;
            do_write(b);
            @(negedge clk);
            n_checks++;
            if (tx !== 1'b1) begin n_fail++; $display("FAIL basic_lat_n0: got %b want 1", tx); end
            @(negedge clk);
            n_checks++;
            if (tx !== 1'b1) begin n_fail++; $display("FAIL basic_lat_n1: got %b want 1", tx); end
            for (int k = 0; k < 10 * TICK; k++) begin
                @(negedge clk);
                if (k < TICK)            exp_bit = 1'b0;
                else if (k >= 9 * TICK)  exp_bit = 1'b1;
                else                     exp_bit = b[k / TICK - 1];
                if (tx !== exp_bit) bad[k / TICK]++;
                if (k == 5 * TICK) begin
                    addr = 1'b1; #1; mid = dat_o; addr = 1'b0;
                end
            end
            for (int i = 0; i < 10; i++) begin
                n_checks++;
                if (bad[i] != 0) begin n_fail++; $display("FAIL basic_bit%0d byte %02h: %0d wrong cycles, want 0", i, b, bad[i]); end
            end
            n_checks++;
            if (mid !== ST_BUSY_EXP) begin n_fail++; $display("FAIL basic_status_mid: got %02h want %02h", mid, ST_BUSY_EXP); end
            repeat (5) @(negedge clk);
            n_checks++;
            if (int_cnt - i0 != 1) begin n_fail++; $display("FAIL basic_int_count: got %0d want 1", int_cnt - i0); end
            @(posedge clk); #1;
            read_status(st);
            n_checks++;
            if (st !== ST_IDLE_EXP) begin n_fail++; $display("FAIL basic_status_after: got %02h want %02h", st, ST_IDLE_EXP); end
            n_checks++;
            if (rx_q.size() != 1 || rx_q[0] !== b) begin
                n_fail++; $display("FAIL basic_rx: got %0d frames first %02h want %02h", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx, b);
            end
            n_checks++;
            if (mon_err != e0) begin n_fail++; $display("FAIL basic_framing: %0d errors want 0", mon_err - e0); end
            $display("test_basic byte %02h done", b);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] pa [2];
        logic [7:0] pb [2];
        logic [7:0] got;
        bit         ok;
        int         i0, e0, d;
        pa[0] = 8'hA3; pb[0] = 8'h0F;
        pa[1] = 8'($urandom_range(0, 255)); pb[1] = 8'($urandom_range(0, 255));
        for (int t = 0; t < 2; t++) begin
            rx_q.delete(); start_q.delete();
            i0 = int_cnt; e0 = mon_err;
            d = $urandom_range(5, 2000);
            do_write(pa[t]);
            repeat (d) @(posedge clk);
            #1;
            do_write(pb[t]);
            wait_rx(2, 30 * TICK, ok);
            n_checks++;
            if (!ok) begin n_fail++; $display("FAIL b2b_timeout: got %0d frames want 2", rx_q.size()); end
            got = (rx_q.size() > 0) ? rx_q[0] : 8'hxx;
            n_checks++;
            if (got !== pa[t]) begin n_fail++; $display("FAIL b2b_first: got %02h want %02h", got, pa[t]); end
            got = (rx_q.size() > 1) ? rx_q[1] : 8'hxx;
            n_checks++;
            if (got !== pb[t]) begin n_fail++; $display("FAIL b2b_second: got %02h want %02h", got, pb[t]); end
            n_checks++;
            if (start_q.size() < 2 || start_q[1] - start_q[0] != 10 * TICK) begin
                n_fail++; $display("FAIL b2b_gap: start spacing %0d want %0d", (start_q.size() > 1) ? start_q[1] - start_q[0] : -1, 10 * TICK);
            end
            n_checks++;
            if (int_cnt - i0 != 2) begin n_fail++; $display("FAIL b2b_int_count: got %0d want 2", int_cnt - i0); end
            n_checks++;
            if (mon_err != e0) begin n_fail++; $display("FAIL b2b_framing: %0d errors want 0", mon_err - e0); end
            $display("test_back_to_back %02h %02h done", pa[t], pb[t]);
        end
    endtask

`ifndef UART_TX_FIFO_EN
    task automatic test_overrun();
        logic [7:0] x [3];
        logic [7:0] st, got;
        bit         ok;
        int         i0;
        for (int i = 0; i < 3; i++) x[i] = 8'($urandom_range(0, 255));
        rx_q.delete();
        i0 = int_cnt;
        do_write(x[0]);
        repeat (50) @(posedge clk);
        #1;
        do_write(x[1]);
        do_write(x[2]);
        read_status(st);
        n_checks++;
        if (st !== 8'h06) begin n_fail++; $display("FAIL ovr_status_set: got %02h want 06", st); end
        read_status(st);
        n_checks++;
        if (st !== 8'h02) begin n_fail++; $display("FAIL ovr_status_clear: got %02h want 02", st); end
        wait_rx(2, 25 * TICK, ok);
        n_checks++;
        if (!ok || rx_q.size() != 2) begin n_fail++; $display("FAIL ovr_frames: got %0d want 2", rx_q.size()); end
        got = (rx_q.size() > 0) ? rx_q[0] : 8'hxx;
        n_checks++;
        if (got !== x[0]) begin n_fail++; $display("FAIL ovr_first: got %02h want %02h", got, x[0]); end
        got = (rx_q.size() > 1) ? rx_q[1] : 8'hxx;
        n_checks++;
        if (got !== x[1]) begin n_fail++; $display("FAIL ovr_second: got %02h want %02h", got, x[1]); end
        n_checks++;
        if (int_cnt - i0 != 2) begin n_fail++; $display("FAIL ovr_int_count: got %0d want 2", int_cnt - i0); end
        read_status(st);
        n_checks++;
        if (st !== ST_IDLE_EXP) begin n_fail++; $display("FAIL ovr_status_end: got %02h want %02h", st, ST_IDLE_EXP); end
        $display("test_overrun done");
    endtask
`else
    task automatic test_fifo();
        logic [7:0] st, got;
        bit         ok;
        int         i0;
        rx_q.delete();
        i0 = int_cnt;
        for (int v = 1; v <= 6; v++) do_write(8'(v));
        read_status(st);
        n_checks++;
        if (st !== 8'h06) begin n_fail++; $display("FAIL fifo_status_full: got %02h want 06", st); end
        wait_rx(5, 60 * TICK, ok);
        n_checks++;
        if (!ok || rx_q.size() != 5) begin n_fail++; $display("FAIL fifo_frames: got %0d want 5", rx_q.size()); end
        for (int v = 1; v <= 5; v++) begin
            got = (rx_q.size() >= v) ? rx_q[v - 1] : 8'hxx;
            n_checks++;
            if (got !== 8'(v)) begin n_fail++; $display("FAIL fifo_order%0d: got %02h want %02h", v, got, 8'(v)); end
        end
        n_checks++;
        if (int_cnt - i0 != 5) begin n_fail++; $display("FAIL fifo_int_count: got %0d want 5", int_cnt - i0); end
        read_status(st);
        n_checks++;
        if (st !== 8'h09) begin n_fail++; $display("FAIL fifo_status_end: got %02h want 09", st); end
        $display("test_fifo done");
    endtask
`endif

    task automatic test_reset_mid();
        logic [7:0] a, c, got;
        bit         ok;
        int         i0, e0;
        a = 8'($urandom_range(0, 255));
        c = 8'($urandom_range(0, 255));
        do_write(a);
        repeat (1 + 4 * TICK + 150) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if (tx !== 1'b1) begin n_fail++; $display("FAIL rstmid_tx: got %b want 1", tx); end
        addr = 1'b1; #1;
        n_checks++;
        if (dat_o !== ST_IDLE_EXP) begin n_fail++; $display("FAIL rstmid_status: got %02h want %02h", dat_o, ST_IDLE_EXP); end
        addr = 1'b0;
        i0 = int_cnt;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2 * TICK) @(posedge clk);
        #1;
        n_checks++;
        if (int_cnt != i0) begin n_fail++; $display("FAIL rstmid_no_int: got %0d pulses want 0", int_cnt - i0); end
        rx_q.delete();
        e0 = mon_err; i0 = int_cnt;
        do_write(c);
        wait_rx(1, 12 * TICK, ok);
        got = (rx_q.size() > 0) ? rx_q[0] : 8'hxx;
        n_checks++;
        if (!ok || got !== c) begin n_fail++; $display("FAIL rstmid_next_frame: got %02h want %02h", got, c); end
        n_checks++;
        if (mon_err != e0 || int_cnt - i0 != 1) begin
            n_fail++; $display("FAIL rstmid_clean: %0d framing errors, %0d ints want 0 and 1", mon_err - e0, int_cnt - i0);
        end
        $display("test_reset_mid done");
    endtask

    task automatic test_stop_coincident();
        logic [7:0] x [3];
        logic [7:0] st, got;
        bit         ok;
        int         i0, d;
        for (int i = 0; i < 3; i++) x[i] = 8'($urandom_range(0, 255));
        d = $urandom_range(20, 1000);
        rx_q.delete();
        i0 = int_cnt;
        do_write(x[0]);
        repeat (d - 1) @(posedge clk);
        #1;
        do_write(x[1]);
        repeat (10 * TICK - d) @(posedge clk);
        #1;
        do_write(x[2]);
        read_status(st);
        n_checks++;
        if (st !== ST_COINC_EXP) begin n_fail++; $display("FAIL coinc_status: got %02h want %02h", st, ST_COINC_EXP); end
        wait_rx(3, 35 * TICK, ok);
        n_checks++;
        if (!ok || rx_q.size() != 3) begin n_fail++; $display("FAIL coinc_frames: got %0d want 3", rx_q.size()); end
        for (int i = 0; i < 3; i++) begin
            got = (rx_q.size() > i) ? rx_q[i] : 8'hxx;
            n_checks++;
            if (got !== x[i]) begin n_fail++; $display("FAIL coinc_order%0d: got %02h want %02h", i, got, x[i]); end
        end
        n_checks++;
        if (int_cnt - i0 != 3) begin n_fail++; $display("FAIL coinc_int_count: got %0d want 3", int_cnt - i0); end
        $display("test_stop_coincident done");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
`ifndef UART_TX_FIFO_EN
        test_overrun();
`else
        test_fifo();
`endif
        test_reset_mid();
        test_stop_coincident();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
